// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver tapping a TX line, buffering received bytes in a small
// FIFO with a valid/ready read port plus framing-error and overflow pulses.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low level on rx_s
// S_START | half-bit wait, then confirm the start bit is still low
// S_DATA  | sample 8 data bits, LSB first, one per bit period
// S_STOP  | sample the stop bit; push the byte or flag a framing error
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_monitor #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_i,
  output logic [7:0]                   rdata_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   level_o
);

  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned TW         = $clog2(ClksPerBit);
  localparam int unsigned AW         = $clog2(FifoDepth);
  localparam logic [TW-1:0] BitLoad  = TW'(ClksPerBit - 1);
  localparam logic [TW-1:0] HalfLoad = TW'(ClksPerBit / 2 - 1);
  localparam logic [AW:0]   FullLvl  = (AW + 1)'(FifoDepth);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q, rx_s;
  logic          tick, push_req, pop, full, wr_en;

  logic [7:0]    mem [FifoDepth];
  logic [AW:0]   wptr_q, rptr_q;

  // Synchroniser resets to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick     = (timer_q == '0);
  assign push_req = (state_q == S_STOP) && tick && rx_s;
  assign pop      = rvalid_o && rready_i;
  assign full     = (level_o == FullLvl);
  assign wr_en    = push_req && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            timer_q <= HalfLoad;
          end
        end
        S_START: begin
          if (!tick) begin
            timer_q <= timer_q - 1'b1;
          end else if (rx_s) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_DATA;
            timer_q   <= BitLoad;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (!tick) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            shift_q <= {rx_s, shift_q[7:1]};
            timer_q <= BitLoad;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
            else                   bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (!tick) begin
            timer_q <= timer_q - 1'b1;
          end else if (rx_s) begin
            state_q <= S_IDLE;
          end else begin
            frame_err_o <= 1'b1;
            state_q     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= shift_q;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= push_req && full && !pop;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  assign level_o  = wptr_q - rptr_q;
  assign rvalid_o = (level_o != '0);
  assign rdata_o  = rvalid_o ? mem[rptr_q[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed and randomized bench for uart_rx_monitor at 10 clocks per bit,
// FIFO depth 4, checked against a queue-based expectation model.
module tb_uart_rx_monitor;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       rready_i;
  logic       frame_err_o;
  logic       overflow_o;
  logic [2:0] level_o;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        rvalid_prev = 1'b0;
  int          n_vcyc = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  model_q[$];

  uart_rx_monitor #(
    .ClockFrequency(1_000_000),
    .BaudRate      (100_000),
    .FifoDepth     (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk_i);
    #1;
    if (rvalid_o && !rvalid_prev) rise_cyc = cyc;
    rvalid_prev = rvalid_o;
    if (rvalid_o) n_vcyc++;
    if (rvalid_o && rready_i) got_q.push_back(rdata_o);
    if (frame_err_o) n_ferr++;
    if (overflow_o) n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame, 10 clocks per bit; optionally assert rready only in the
  // cycle whose rising edge samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      rx_i = v;
      for (int c = 0; c < 10; c++) begin
        if (pop_at_stop && i == 9 && c == 7) rready_i = 1'b1;
        if (pop_at_stop && i == 9 && c == 8) rready_i = 1'b0;
        @(negedge clk_i);
      end
    end
    rx_i = 1'b1;
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_byte"}, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
  endtask

  initial begin
    int unsigned start_cyc;
    int          v0, e0, o0;
    logic [7:0]  rb;
    logic [7:0]  b99;

    rst_ni   = 1'b0;
    rx_i     = 1'b1;
    rready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_rvalid", rvalid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovf", overflow_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);

    // single frame with latency measurement
    rready_i = 1'b1;
    got_q.delete();
    v0 = n_vcyc; e0 = n_ferr; o0 = n_ovf;
    start_cyc = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge clk_i);
    check("single_valid_cycles", n_vcyc - v0, 1);
    check("single_latency_ok", ((rise_cyc - start_cyc) >= 96) && ((rise_cyc - start_cyc) <= 99), 1);
    check("single_errs", (n_ferr - e0) + (n_ovf - o0), 0);
    exp_q = '{8'h55};
    check_got("single");

    // back-to-back fill, overflow, then push with simultaneous pop
    rready_i = 1'b0;
    got_q.delete();
    model_q.delete();
    exp_q.delete();
    o0 = n_ovf;
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      logic [7:0] b2b [4];
      b2b = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
      for (int i = 0; i < 4; i++) begin
        send_frame(b2b[i], 1'b1, 1'b0);
        model_q.push_back(b2b[i]);
      end
    end
    repeat (3) @(negedge clk_i);
    check("b2b_level", level_o, model_q.size());
    check("b2b_rvalid", rvalid_o, 1);
    check("b2b_head", rdata_o, model_q[0]);

    send_frame(8'h77, 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    check("ovf_pulses", n_ovf - o0, 1);
    check("ovf_level", level_o, 4);
    check("ovf_head", rdata_o, model_q[0]);

    o0 = n_ovf;
    send_frame(8'h88, 1'b1, 1'b1);
    exp_q.push_back(model_q.pop_front());
    model_q.push_back(8'h88);
    repeat (3) @(negedge clk_i);
    check("popush_no_ovf", n_ovf - o0, 0);
    check("popush_level", level_o, 4);
    check("popush_head", rdata_o, model_q[0]);
    rready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    while (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    check("drain_level", level_o, 0);
    check_got("drain");

    // framing error followed by a held-low break
    got_q.delete();
    e0 = n_ferr;
    send_frame(8'h12, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (50) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("ferr_break_pulses", n_ferr - e0, 1);
    send_frame(8'h34, 1'b1, 1'b0);
    repeat (5) @(negedge clk_i);
    check("ferr_pulses", n_ferr - e0, 1);
    exp_q = '{8'h34};
    check_got("ferr");

    // short glitch must be rejected as a false start
    got_q.delete();
    e0 = n_ferr; v0 = n_vcyc;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("glitch_valid", n_vcyc - v0, 0);
    check("glitch_ferr", n_ferr - e0, 0);
    check("glitch_level", level_o, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (5) @(negedge clk_i);
    exp_q = '{8'hC3};
    check_got("glitch");

    // randomized bytes with random idle gaps
    got_q.delete();
    exp_q.delete();
    e0 = n_ferr; o0 = n_ovf;
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0);
      exp_q.push_back(rb);
      repeat ($urandom_range(0, 12)) @(negedge clk_i);
    end
    repeat (5) @(negedge clk_i);
    check("rand_errs", (n_ferr - e0) + (n_ovf - o0), 0);
    check_got("rand");

    // reset during bit 4 of 0x99 with two bytes queued
    rready_i = 1'b0;
    got_q.delete();
    e0 = n_ferr;
    for (int i = 0; i < 2; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    check("prerst_level", level_o, 2);
    b99 = 8'h99;
    rx_i = 1'b0;
    repeat (10) @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      rx_i = b99[i];
      repeat ((i == 4) ? 5 : 10) @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    check("midrst_rvalid", rvalid_o, 0);
    check("midrst_level", level_o, 0);
    check("midrst_rdata", rdata_o, 0);
    check("midrst_ferr", frame_err_o, 0);
    check("midrst_ovf", overflow_o, 0);
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    rready_i = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (20) @(negedge clk_i);
    check("postrst_ferr", n_ferr - e0, 0);
    exp_q = '{8'h5A};
    check_got("postrst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
RTL UART receiver for the Verilator top level that taps the system's UART TX line. It deserialises 8N1 frames into bytes and buffers them in a small FIFO. Bytes are presented on a valid/ready interface for a checker or scoreboard. It runs alongside the virtual UART and gives in-simulation, cycle-accurate visibility of console output, including framing and overflow events.

Parameters:
ClockFrequency, 50_000_000, system clock in Hz.
BaudRate, 115_200, line rate in bit/s. ClksPerBit = ClockFrequency / BaudRate, integer division (434 at defaults). Must be >= 4.
FifoDepth, 8, byte FIFO entries. Power of two, >= 2.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
rx_i  input  1  serial line from system UART TX, idle high, asynchronous to frame timing
rdata_o  output  8  byte at FIFO head
rvalid_o  output  1  FIFO non-empty
rready_i  input  1  consumer accepts rdata_o when rvalid_o && rready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overflow_o  output  1  one-cycle pulse: good byte dropped, FIFO full
level_o  output  $clog2(FifoDepth)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0. FSM in IDLE. FIFO empty. Synchroniser flops reset to 1 (line idle).
- rx_i passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s.
- Bit timer counts down from a load value. Bit counter runs 0..7.
- IDLE: on rx_s == 0, go to START and load timer with ClksPerBit/2 - 1.
- START: at timer expiry sample rx_s.
  - rx_s == 1: false start, return to IDLE. No error.
  - rx_s == 0: go to DATA, load ClksPerBit-1, bit count 0.
- DATA: at each expiry, shift rx_s into the shift register MSB and shift right (LSB first on the line). Reload ClksPerBit-1. After the 8th sample go to STOP.
- STOP: at expiry sample rx_s.
  - rx_s == 1: push the byte and return to IDLE.
  - rx_s == 0: pulse frame_err_o, discard the byte, go to BREAK.
- BREAK: wait for rx_s == 1, then go to IDLE. A line held low never produces further frames or errors.
- Push timing: the byte is written in the cycle of the stop sample. rvalid_o and level_o update the following cycle.
- Push while full, with no simultaneous pop: drop the byte and pulse overflow_o in the push cycle. FIFO contents are unchanged.
- Push while full with a simultaneous pop: both happen, level stays FifoDepth, no overflow.
- Push and pop while empty: the pop is ignored (rvalid_o is 0). The push is accepted and level becomes 1.
- Pop: when rvalid_o && rready_i, the head advances next cycle. rdata_o is the head entry and must hold stable while rvalid_o && !rready_i.
- Read/write pointers have an extra wrap bit, and level is the pointer difference. Wrap-around past FifoDepth must be seamless.
- Mid-frame reset clears the FSM and FIFO. The next valid start after reset deassertion is received normally. A partial frame in progress at reset is lost and produces no error.
- Sample point latency from the falling start edge is 2 + ClksPerBit/2 + k*ClksPerBit cycles for bit k (data bits k=1..8, stop bit k=9). This must hold within ±1 cycle.

Test Plan:
Bench setting: ClockFrequency=1_000_000, BaudRate=100_000 (ClksPerBit=10), FifoDepth=4.
- Single frame: drive 0x55 as 8N1 at 10 clk/bit, rready_i=1. Required: rvalid_o high for exactly 1 cycle with rdata_o=0x55, at ~97 cycles after the start edge. No error pulses.
- Back-to-back: send 0x00, 0xFF, 0xA5, 0x3C with no idle gap, rready_i=0. Required: level_o=4 and rvalid_o=1, then pops yield 0x00, 0xFF, 0xA5, 0x3C in order.
- Overflow: with the FIFO full (4 entries) and rready_i=0, send 0x77. Required: overflow_o pulses once, level_o stays 4, head stays the first byte. Then send 0x88 with rready_i=1 held in the stop-sample cycle. Required: no overflow, 0x88 becomes the last entry.
- Framing error: send 0x12 with the stop bit low, then hold the line low 50 cycles, then idle high, then send 0x34. Required: frame_err_o pulses once, 0x12 not stored, only 0x34 delivered.
- Glitch: pull rx_i low for 3 cycles, then high. Required: no byte, no error, FSM back in IDLE. A following 0xC3 frame is received correctly.
- Reset mid-frame: assert rst_ni low during bit 4 of 0x99 with 2 bytes already queued. Required: all outputs 0 immediately and level_o=0. After release, a fresh 0x5A frame is delivered alone.
